// File: rtl/cpu_pkg.sv
// Shared types for the VeriRISC instruction-sequencing controller: opcodes, FSM states and the
// ALU-class opcode predicate.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    // Opcodes that read a memory operand and load the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// VeriRISC fetch/execute sequencer: 8 phases per instruction, HLT parks in HALTED until reset.
// Optional CPU_CTRL_MEM_WAIT_EN adds mem_rdy, stalling INST_FETCH/OP_FETCH while it is low.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned PHASES = 8
) (
    input  logic    clk,
    input  logic    rst,
`ifdef CPU_CTRL_MEM_WAIT_EN
    input  logic    mem_rdy,
`endif
    input  opcode_t opcode,
    input  logic    zero,
    output logic    sel,
    output logic    rd,
    output logic    ld_ir,
    output logic    inc_pc,
    output logic    ld_pc,
    output logic    ld_ac,
    output logic    wr,
    output logic    data_e,
    output logic    halt
);

    if (PHASES != 8) begin : g_phases_chk
        $error("cpu_ctrl: PHASES must be 8");
    end

    state_t state_q, state_d;
    logic   stall;
    logic   aluop;

`ifdef CPU_CTRL_MEM_WAIT_EN
    assign stall = ~mem_rdy;
`else
    assign stall = 1'b0;
`endif

    assign aluop = is_aluop(opcode);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INST_ADDR:  state_d = INST_FETCH;
            INST_FETCH: state_d = stall ? INST_FETCH : INST_LOAD;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (opcode == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_d = stall ? OP_FETCH : ALU_OP;
            ALU_OP:     state_d = STORE;
            STORE:      state_d = INST_ADDR;
            HALTED:     state_d = HALTED;
            default:    state_d = INST_ADDR;
        endcase
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        unique case (state_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: rd = aluop;
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == SKZ) && zero;
                ld_pc  = (opcode == JMP);
                data_e = (opcode == STO);
            end
            STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                inc_pc = (opcode == JMP);
                ld_pc  = (opcode == JMP);
                wr     = (opcode == STO);
                data_e = (opcode == STO);
            end
            HALTED: halt = 1'b1;
            default: begin
                sel    = 1'bx;
                rd     = 1'bx;
                ld_ir  = 1'bx;
                inc_pc = 1'bx;
                ld_pc  = 1'bx;
                ld_ac  = 1'bx;
                wr     = 1'bx;
                data_e = 1'bx;
                halt   = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INST_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed instruction walks plus a randomized run, all checked
// against a phase-counter reference model.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic    clk;
    logic    rst;
    logic    zero;
    logic    mem_rdy;
    opcode_t opcode;
    logic    sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase index 0..7 within the instruction, plus a sticky halted flag.
    int m_phase  = 0;
    bit m_halted = 0;
    bit m_valid  = 0;

    cpu_ctrl #(.PHASES(8)) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef CPU_CTRL_MEM_WAIT_EN
        .mem_rdy(mem_rdy),
`endif
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}.
    function automatic logic [8:0] model_out(input int ph, input bit hlt, input int op, input bit z);
        bit s = 0, r = 0, li = 0, ip = 0, lp = 0, la = 0, w = 0, de = 0, h = 0;
        bit alu = (op >= 2) && (op <= 5);
        if (hlt) return 9'b0_0000_0001;
        case (ph)
            0: s = 1;
            1: begin s = 1; r = 1; end
            2, 3: begin s = 1; r = 1; li = 1; end
            4: begin ip = 1; h = (op == 0); end
            5: r = alu;
            6: begin r = alu; ip = (op == 1) && z; lp = (op == 7); de = (op == 6); end
            7: begin
                r = alu; la = alu; ip = (op == 7); lp = (op == 7); w = (op == 6); de = (op == 6);
            end
            default: ;
        endcase
        return {s, r, li, ip, lp, la, w, de, h};
    endfunction

    task automatic cycle(input int op, input bit z, input bit r, input bit rdy);
        @(negedge clk);
        opcode  = opcode_t'(op[2:0]);
        zero    = z;
        rst     = r;
        mem_rdy = rdy;
        #1;
        if (m_valid)
            check_eq($sformatf("outs ph%0d hlt%0d op%0d z%0d", m_phase, m_halted, op, z),
                     {23'b0, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt},
                     {23'b0, model_out(m_phase, m_halted, op, z)});
        @(posedge clk);
        if (r) begin
            m_phase  = 0;
            m_halted = 0;
            m_valid  = 1;
        end else if (!m_halted) begin
            bit stalled = 0;
`ifdef CPU_CTRL_MEM_WAIT_EN
            stalled = ((m_phase == 1) || (m_phase == 5)) && !rdy;
`endif
            if (m_phase == 4 && op == 0) m_halted = 1;
            else if (!stalled) m_phase = (m_phase + 1) % 8;
        end
    endtask

    // One full instruction from INST_ADDR; HLT stops early when the model parks.
    task automatic run_instr(input int op, input bit z);
        for (int i = 0; i < 8; i++) begin
            if (m_halted) break;
            cycle(op, z, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int op;
        rst = 1'b1; zero = 1'b0; mem_rdy = 1'b1; opcode = HLT;

        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);

        run_instr(2, 0);
        run_instr(6, 0);
        run_instr(7, 1);
        run_instr(1, 1);
        run_instr(1, 0);
        run_instr(5, 1);
        run_instr(3, 0);
        run_instr(4, 1);
        check_eq("phase after 8 instr", m_phase, 0);

        run_instr(0, 0);
        check_eq("model halted", {31'b0, m_halted}, 1);
        for (int i = 0; i < 25; i++) cycle($urandom_range(0, 7), $urandom_range(0, 1), 0, 1);
        cycle(2, 0, 1, 1);
        cycle(2, 0, 0, 1);

        // Mid-instruction reset taken in ALU_OP.
        for (int i = 0; i < 16 && m_phase != 6; i++) cycle(7, 0, 0, 1);
        check_eq("reached ALU_OP", m_phase, 6);
        cycle(7, 0, 1, 1);
        run_instr(2, 0);

`ifdef CPU_CTRL_MEM_WAIT_EN
        begin
            int n = 0;
            cycle(2, 0, 0, 1);
            for (int i = 0; i < 3; i++) begin cycle(2, 0, 0, 0); n++; end
            for (int i = 0; i < 20 && m_phase != 0; i++) begin cycle(2, 0, 0, 1); n++; end
            check_eq("stalled instr length", n + 1, 11);
        end
`endif

        op = 2;
        for (int i = 0; i < 3000; i++) begin
            if (m_phase == 0 || m_halted) op = $urandom_range(0, 7);
            cycle(op, $urandom_range(0, 1), ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Instruction-sequencing controller for the VeriRISC training CPU.
- Sits directly upstream of the address multiplexor: its `sel` output drives the mux select.
  - sel=1 selects the program-counter address.
  - sel=0 selects the instruction-register operand address.
- Steps through an 8-phase fetch/execute cycle per instruction.
- Decodes the 3-bit opcode and zero flag into memory, register, PC and accumulator strobes.

Parameters:
- PHASES, 8, number of phases per instruction; fixed at 8; any other value is flagged by an elaboration `$error`.

Ports:
- clk     input   1  rising-edge clock.
- rst     input   1  synchronous, active-high reset.
- opcode  input   3  cpu_pkg::opcode_t from the instruction register: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7.
- zero    input   1  accumulator-zero flag.
- sel     output  1  address mux select (1 = PC address).
- rd      output  1  memory read strobe.
- ld_ir   output  1  instruction register load.
- inc_pc  output  1  program counter increment.
- ld_pc   output  1  program counter load (jump).
- ld_ac   output  1  accumulator load.
- wr      output  1  memory write strobe.
- data_e  output  1  data bus drive enable.
- halt    output  1  processor halted (sticky).

Behaviour:
- State register of type cpu_pkg::state_t:
  - Cycle states: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
  - Terminal state: HALTED.
- Reset: state <= INST_ADDR on any clk edge with rst=1. Reset overrides everything, including HALTED and mid-instruction phases.
- Transitions:
  - Each cycle advances one phase: INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE -> OP_ADDR -> OP_FETCH -> ALU_OP -> STORE -> INST_ADDR.
  - In OP_ADDR with opcode==HLT, next state is HALTED instead of OP_FETCH.
  - HALTED holds until rst.
- Outputs are combinational from state plus opcode/zero (Moore-with-decode). All outputs default to 0.
  - ALUOP is the condition opcode ∈ {ADD, AND, XOR, LDA}.
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=(opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=(opcode==JMP); ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
  - HALTED: halt=1, all others 0.
- Output values during reset follow state INST_ADDR after the first edge: sel=1, all other outputs 0.
- opcode is sampled every cycle, not latched. The upstream IR holds opcode stable from IDLE through STORE.
- Unknown/illegal state: `unique case` default drives all outputs 'x and next state INST_ADDR.
- One instruction = 8 cycles, unconditionally, except HLT, which ends after OP_ADDR.

Optional Feature:
- Macro: CPU_CTRL_MEM_WAIT_EN.
- With the macro defined:
  - Adds input port `mem_rdy` (1 bit).
  - INST_FETCH and OP_FETCH hold their state while mem_rdy=0. Outputs stay those of the held phase, so rd stays asserted.
  - The FSM advances on the first cycle with mem_rdy=1.
  - mem_rdy is ignored in all other states.
  - rst still overrides a stall.
- Without the macro: no mem_rdy port; the fixed 8-cycle cadence applies.

Decomposition:
- cpu_pkg contains:
  - `opcode_t`: 3-bit enum HLT..JMP.
  - `state_t`: enum of the 9 states with explicit 4-bit encoding.
  - `is_aluop()`: function returning the ALUOP condition.
- Single module. No sub-module is natural: the next-state and output decode are two `always_comb` blocks plus one `always_ff`.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> sel=1, other outputs 0, INST_ADDR. Phase sequence INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE observed on the next 7 edges.
- ADD (opcode=2): rd=1 in OP_FETCH, ALU_OP and STORE; ld_ac=1 only in STORE; wr=0 and data_e=0 throughout; next instruction begins at cycle 8.
- STO (opcode=6) -> data_e=1 in ALU_OP and STORE, wr=1 only in STORE, rd=0 in OP_FETCH through STORE. JMP (opcode=7) -> ld_pc=1 in ALU_OP and STORE, inc_pc=1 in STORE.
- SKZ (opcode=1):
  - zero=1 -> inc_pc=1 in both OP_ADDR and ALU_OP.
  - zero=0 -> inc_pc=1 only in OP_ADDR.
- HLT (opcode=0) -> halt=1 in OP_ADDR, then HALTED with halt=1 for ≥20 cycles. rst=1 -> INST_ADDR, halt=0. A mid-instruction rst (asserted in ALU_OP) also returns to INST_ADDR on the next edge.
- With CPU_CTRL_MEM_WAIT_EN defined, hold mem_rdy=0 for 3 cycles in INST_FETCH -> state held, rd=1, sel=1. The instruction then completes in 11 cycles total.
